// File: rtl/bcd_clock_pkg.sv
// Shared types, limits and validity helpers for the BCD time-of-day counter.
package bcd_clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t h2;
        bcd_t h1;
        bcd_t m2;
        bcd_t m1;
        bcd_t s2;
        bcd_t s1;
    } time_t;

    localparam bcd_t        DIGIT_MAX    = 4'd9;
    localparam bcd_t        SEC_TENS_MAX = 4'd5;
    localparam bcd_t        MIN_TENS_MAX = 4'd5;
    localparam bcd_t        HOUR_TENS_MAX = 4'd2;
    localparam int unsigned HOUR_MAX     = 23;
    localparam int unsigned HOUR_W       = 5;

    // Binary hour value of a two-digit BCD hour (tens digit assumed <= 2)
    function automatic logic [HOUR_W-1:0] hour_bin(input bcd_t h2, input bcd_t h1);
        return HOUR_W'(h2) * HOUR_W'(10) + HOUR_W'(h1);
    endfunction

    // True when every digit is decimal and the time is a legal 24-hour time
    function automatic logic bcd_time_valid(input time_t t);
        return (t.s1 <= DIGIT_MAX) && (t.s2 <= SEC_TENS_MAX) &&
               (t.m1 <= DIGIT_MAX) && (t.m2 <= MIN_TENS_MAX) &&
               (t.h1 <= DIGIT_MAX) && (t.h2 <= HOUR_TENS_MAX) &&
               (hour_bin(t.h2, t.h1) <= HOUR_W'(HOUR_MAX));
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: clear > load > increment, wraps at MAX and reports a carry.
module bcd_digit_counter
    import bcd_clock_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic clear,
    input  logic inc,
    input  logic load,
    input  bcd_t load_val,
    output bcd_t q,
    output bcd_t nxt_c,
    output logic carry_out
);

    // Next digit value, exported so the top can look one cycle ahead
    always_comb begin
        nxt_c = q;
        if (clear) begin
            nxt_c = '0;
        end else if (load) begin
            nxt_c = load_val;
        end else if (inc) begin
            nxt_c = (q == MAX) ? '0 : q + 4'd1;
        end
    end

    assign carry_out = inc & ~clear & ~load & (q == MAX);

    // Digit register
    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else begin
            q <= nxt_c;
        end
    end

endmodule

// File: rtl/bcd_clock_counter.sv
// HH:MM:SS BCD time-of-day counter with prescaler, run/pause, validated load
// and 12/24-hour display. Optional alarm enabled by BCD_CLOCK_ALARM_EN.
module bcd_clock_counter
    import bcd_clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned CNT_W    = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        mode_12h,
    input  logic        set_valid,
    output logic        set_ready,
    input  logic [23:0] set_time,
    output logic        set_err,
    output logic [3:0]  sec_1,
    output logic [3:0]  sec_2,
    output logic [3:0]  min_1,
    output logic [3:0]  min_2,
    output logic [3:0]  hour_1,
    output logic [3:0]  hour_2,
    output logic        pm,
    output logic        sec_pulse,
    output logic        day_wrap,
    input  logic        alarm_set,
    input  logic [15:0] alarm_time,
    input  logic        alarm_ack,
    output logic        alarm_on
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] presc_q;
    time_t            set_t_c;
    logic             set_ok_c;
    logic             accept_c;
    logic             load_ok_c;
    logic             load_bad_c;
    logic             tick_c;
    logic             adv_c;
    logic             alarm_bad_c;

    bcd_t s1_q, s2_q, m1_q, m2_q;
    bcd_t s1_n, s2_n, m1_n, m2_n;
    logic s1_co, s2_co, m1_co, m2_co;

    bcd_t h2_q, h1_q, h2_n, h1_n;
    logic day_wrap_c;

    logic [HOUR_W-1:0] hour_n_bin;
    logic [HOUR_W-1:0] hour_12_bin;
    bcd_t              disp_h2_c;
    bcd_t              disp_h1_c;
    logic              pm_c;

    assign set_t_c    = time_t'(set_time);
    assign set_ok_c   = bcd_time_valid(set_t_c);
    assign set_ready  = ~rst;
    assign accept_c   = set_valid & set_ready;
    assign load_ok_c  = accept_c & set_ok_c;
    assign load_bad_c = accept_c & ~set_ok_c;
    assign tick_c     = run & (presc_q == PRESC_LAST);
    // Any accepted load request owns the cycle, so a coincident tick is dropped
    assign adv_c      = tick_c & ~accept_c;

    // Prescaler: free-runs while run=1, holds its value while paused, restarts on load
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else if (load_ok_c) begin
            presc_q <= '0;
        end else if (run) begin
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + CNT_W'(1);
        end
    end

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_s1 (
        .clk(clk), .clear(rst), .inc(adv_c), .load(load_ok_c), .load_val(set_t_c.s1),
        .q(s1_q), .nxt_c(s1_n), .carry_out(s1_co)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_s2 (
        .clk(clk), .clear(rst), .inc(s1_co), .load(load_ok_c), .load_val(set_t_c.s2),
        .q(s2_q), .nxt_c(s2_n), .carry_out(s2_co)
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_m1 (
        .clk(clk), .clear(rst), .inc(s2_co), .load(load_ok_c), .load_val(set_t_c.m1),
        .q(m1_q), .nxt_c(m1_n), .carry_out(m1_co)
    );

    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_m2 (
        .clk(clk), .clear(rst), .inc(m1_co), .load(load_ok_c), .load_val(set_t_c.m2),
        .q(m2_q), .nxt_c(m2_n), .carry_out(m2_co)
    );

    assign sec_1 = s1_q;
    assign sec_2 = s2_q;
    assign min_1 = m1_q;
    assign min_2 = m2_q;

    assign day_wrap_c = m2_co & (hour_bin(h2_q, h1_q) == HOUR_W'(HOUR_MAX));

    // Next internal hour: 24-hour BCD pair wrapping 23 -> 00
    always_comb begin
        h2_n = h2_q;
        h1_n = h1_q;
        if (rst) begin
            h2_n = '0;
            h1_n = '0;
        end else if (load_ok_c) begin
            h2_n = set_t_c.h2;
            h1_n = set_t_c.h1;
        end else if (m2_co) begin
            if (hour_bin(h2_q, h1_q) == HOUR_W'(HOUR_MAX)) begin
                h2_n = '0;
                h1_n = '0;
            end else if (h1_q == DIGIT_MAX) begin
                h2_n = h2_q + 4'd1;
                h1_n = '0;
            end else begin
                h1_n = h1_q + 4'd1;
            end
        end
    end

    // Display hour from the next internal hour so it lands together with the other digits
    always_comb begin
        hour_n_bin  = hour_bin(h2_n, h1_n);
        hour_12_bin = hour_n_bin;
        disp_h2_c   = h2_n;
        disp_h1_c   = h1_n;
        pm_c        = 1'b0;
        if (mode_12h) begin
            pm_c = (hour_n_bin >= HOUR_W'(12));
            if (hour_n_bin == '0) begin
                hour_12_bin = HOUR_W'(12);
            end else if (hour_n_bin > HOUR_W'(12)) begin
                hour_12_bin = hour_n_bin - HOUR_W'(12);
            end
            if (hour_12_bin >= HOUR_W'(10)) begin
                disp_h2_c = 4'd1;
                disp_h1_c = 4'(hour_12_bin - HOUR_W'(10));
            end else begin
                disp_h2_c = 4'd0;
                disp_h1_c = 4'(hour_12_bin);
            end
        end
    end

    // Hour state, display hour and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            h2_q      <= '0;
            h1_q      <= '0;
            hour_2    <= '0;
            hour_1    <= '0;
            pm        <= 1'b0;
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            h2_q      <= h2_n;
            h1_q      <= h1_n;
            hour_2    <= disp_h2_c;
            hour_1    <= disp_h1_c;
            pm        <= pm_c;
            sec_pulse <= adv_c;
            day_wrap  <= adv_c & day_wrap_c;
            set_err   <= load_bad_c | alarm_bad_c;
        end
    end

`ifdef BCD_CLOCK_ALARM_EN
    logic [15:0] alarm_q;
    logic        armed_q;
    logic        alarm_ok_c;
    logic        alarm_match_c;

    assign alarm_ok_c  = bcd_time_valid(time_t'({alarm_time, 8'h00}));
    assign alarm_bad_c = alarm_set & ~rst & ~alarm_ok_c;
    // Only a real tick can fire the alarm; loads never advance the time through adv_c
    assign alarm_match_c = armed_q & adv_c & (s2_n == '0) & (s1_n == '0) &
                           ({h2_n, h1_n, m2_n, m1_n} == alarm_q);

    // Alarm time, arm flag and sticky alarm output
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q  <= '0;
            armed_q  <= 1'b0;
            alarm_on <= 1'b0;
        end else begin
            if (alarm_set && alarm_ok_c) begin
                alarm_q <= alarm_time;
                armed_q <= 1'b1;
            end
            if (alarm_match_c) begin
                alarm_on <= 1'b1;
            end else if (alarm_ack) begin
                alarm_on <= 1'b0;
            end
        end
    end
`else
    logic unused_alarm_c;

    assign alarm_bad_c    = 1'b0;
    assign alarm_on       = 1'b0;
    assign unused_alarm_c = ^{alarm_set, alarm_time, alarm_ack, s1_n, s2_n, m1_n, m2_n};
`endif

endmodule
